// File: rtl/mdu_multi.sv
// Multi-cycle multiply/divide unit with HI/LO for the EX stage; result lands LAT edges after start.
// Define MDU_MADD_EN to build the madd/maddu/msub/msubu accumulate ops (codes 6-9).
module mdu_multi #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT) + 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);

  localparam logic [3:0] OP_MULT  = 4'd0, OP_MULTU = 4'd1, OP_DIV   = 4'd2, OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4, OP_MTLO  = 4'd5, OP_MADD  = 4'd6, OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8, OP_MSUBU = 4'd9;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_q;
`endif

  logic is_mul, is_div, is_acc;
  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
    is_div = (op == OP_DIV)  || (op == OP_DIVU);
    is_acc = 1'b0;
`ifdef MDU_MADD_EN
    is_acc = (op >= OP_MADD) && (op <= OP_MSUBU);
`endif
  end

  // Result is formed from the captured operands; only the final edge makes it visible.
  logic               sgn, a_neg, b_neg;
  logic [2*WIDTH-1:0] ax, bx, prod, res_d;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;

  always_comb begin
    sgn   = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ax    = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    bx    = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ax * bx;
    a_neg = sgn & a_q[WIDTH-1];
    b_neg = sgn & b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    // MIN / -1 falls out of the magnitude path: |MIN| / 1 wraps back to MIN, remainder 0.
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end
    res_d = {hi_q, lo_q};
    case (op_q)
      OP_MULT, OP_MULTU: res_d = prod;
      OP_DIV, OP_DIVU:   res_d = {rem, quo};
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: res_d = acc_q + prod;
      OP_MSUB, OP_MSUBU: res_d = acc_q - prod;
`endif
      default:           res_d = {hi_q, lo_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_MADD_EN
      acc_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_mul || is_div || is_acc) begin
              op_q    <= op;
              a_q     <= a;
              b_q     <= b;
              cnt_q   <= is_div ? DIV_CNT : MUL_CNT;
              state_q <= S_RUN;
`ifdef MDU_MADD_EN
              acc_q   <= {hi_q, lo_q};
`endif
            end else if (op == OP_MTHI) begin
              hi_q <= a;
            end else if (op == OP_MTLO) begin
              lo_q <= a;
            end
          end
        end
        S_RUN: begin
          // start is deliberately ignored here, mthi/mtlo included.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            {hi_q, lo_q} <= res_d;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_multi.sv
// Scoreboard bench for mdu_multi: expectations queued at issue, popped when busy falls.
module tb_mdu_multi;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mdu_multi #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   bcnt = 0;
  logic bprev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count busy cycles; on the falling edge of busy compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      bcnt  = 0;
      bprev = 1'b0;
    end else begin
      if (busy) bcnt++;
      else if (bprev) begin
        if (sb.size() == 0) chk("sb_empty", 64'(sb.size()), 64'd1);
        else begin
          e = sb.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("busy_len", 64'(bcnt), 64'(e.lat));
        end
        bcnt = 0;
      end
      bprev = busy;
    end
  end

  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      4'd0: p = sx * sy;
      4'd1: p = {32'b0, x} * {32'b0, y};
      4'd2: if (y == 0) p = {x, 32'hFFFF_FFFF};
            else begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
      4'd3: if (y == 0) p = {x, 32'hFFFF_FFFF};
            else p = {x % y, x / y};
      default: p = '0;
    endcase
    {h, l} = p;
  endfunction

  task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int lat);
    exp_t e;
    e.hi = h; e.lo = l; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy === 1'b1 || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("timeout_sb", 64'(sb.size()), 64'd0);
  endtask

  task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] h, input logic [31:0] l, input int lat);
    push(h, l, lat);
    drive(o, x, y);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] mh, ml, x, y;
    logic [3:0]  o;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    #1 reset = 1'b1;

    run(4'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, ML);
    run(4'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, ML);

    run(4'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DL);
    run(4'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, DL);
    run(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DL);

    drive(4'd4, 32'h1234_5678, 32'h0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'h8000_0000);
    chk("mthi_busy", busy, 1'b0);

    // mtlo issued mid-RUN must not disturb the mult result
    push(32'h0, 32'd30, ML);
    drive(4'd0, 32'd5, 32'd6);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; op = 4'd5; a = 32'hDEAD_BEEF;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("mtlo_ignored", lo, 32'd30);

    drive(4'd4, 32'h0, 32'h0);
    drive(4'd5, 32'hFFFF_FFFF, 32'h0);
`ifdef MDU_MADD_EN
    run(4'd6, 32'd1, 32'd1, 32'd1, 32'd0, ML);
    drive(4'd4, 32'h0, 32'h0);
    drive(4'd5, 32'hFFFF_FFFF, 32'h0);
    run(4'd8, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFE, ML);
`else
    drive(4'd6, 32'd1, 32'd1);
    @(negedge clk);
    chk("madd_off_busy", busy, 1'b0);
    chk("madd_off_hi", hi, 32'h0);
    chk("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif
    drive(4'd15, 32'h5555_5555, 32'h1);
    @(negedge clk);
    chk("noop_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      o = 4'($urandom_range(0, 3));
      x = $urandom;
      y = (i == 0) ? 32'd0 : ((i % 3 == 1) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom);
      model(o, x, y, mh, ml);
      run(o, x, y, mh, ml, (o >= 4'd2) ? DL : ML);
    end

    // async reset in the middle of a div discards it
    push(32'd2, 32'd14, DL);
    drive(4'd2, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    @(negedge clk);
    #1 reset = 1'b1;
    run(4'd0, 32'd3, 32'd4, 32'd0, 32'd12, ML);

    // start held high: div seen at k+5 is ignored, accepted at k+6
    push(32'd0, 32'd42, ML);
    push(32'd2, 32'd14, DL);
    @(posedge clk); #1;
    start = 1'b1; op = 4'd0; a = 32'd6; b = 32'd7;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 op = 4'd2; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_gap", busy, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_div_busy", busy, 1'b1);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
